life_ctrl: RTL and testbench
============================

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 Parameter COLS, default 800, grid width in cells.
REQ-002 Parameter ROWS, default 600, grid height in cells.
REQ-003 Parameter CW, default 12, cursor coordinate width.
REQ-004 Parameter AW, default 24, linear cell address width.
REQ-005 Parameter GW, default 16, generation counter width.
REQ-006 Parameter BASE_TICKS, default 50000000, evolution period in cycles at speed 0.
REQ-007 Parameter WRAP, default 0; 1 = cursor wraps at grid edges, 0 = cursor clamps.
REQ-008 Ports:
  clk  in  1  single clock, all logic on rising edge.
  rst  in  1  synchronous reset, active-high.
  start  in  1  one-cycle pulse, start/resume.
  pause  in  1  one-cycle pulse, pause.
  clear  in  1  one-cycle pulse, clear grid and return to idle.
  step  in  1  one-cycle pulse, single generation while paused.
  manual  in  1  level; 1 requests cursor-setting mode.
  dir  in  4  one-hot cursor move: bit0 left, bit1 up, bit2 down, bit3 right.
  edit  in  1  one-cycle pulse, toggle cell under cursor.
  speed  in  3  period select.
  load_done  in  1  level; grid init/preset load complete.
  round_done  in  1  one-cycle pulse; evolution round finished.
  state  out  3  FSM state code.
  bank  out  1  ping-pong buffer select; display reads bank, evolution writes ~bank.
  evo_start  out  1  one-cycle pulse, begin one evolution round.
  init_req  out  1  one-cycle pulse, request grid re-initialisation.
  edit_we  out  1  one-cycle pulse, toggle cell at cursor_addr.
  cursor_x  out  CW  cursor column.
  cursor_y  out  CW  cursor row.
  cursor_addr  out  AW  cursor_y*COLS + cursor_x.
  generation  out  GW  completed generations since clear.

Function
REQ-009 States: IDLE=0, PAUSE=1, RUN=2, SET=3, STEP=4; other codes unreachable, decode to IDLE.
REQ-010 IDLE: start and load_done -> PAUSE; else manual and load_done -> SET (return target IDLE); else stay; start without load_done ignored.
REQ-011 PAUSE priority: start -> RUN; step -> STEP; clear -> IDLE; manual -> SET (return target PAUSE).
REQ-012 RUN priority: pause -> PAUSE; clear -> IDLE.
REQ-013 STEP: evo_start pulses on entry cycle+1 if no round outstanding, else once outstanding round completes; return to PAUSE on round_done of that round; clear -> IDLE.
REQ-014 SET: manual=0 -> return target next cycle; edit pulses edit_we same-registered cycle (1-cycle latency); start/pause/step ignored.
REQ-015 Outstanding flag: set on evo_start, cleared on round_done; evo_start never pulses while set.
REQ-016 RUN tick counter: counts 0..P-1, P = max(BASE_TICKS >> speed, 1), speed sampled at reload; at P-1 holds until outstanding=0, then evo_start pulses and counter reloads 0.
REQ-017 Counter resets to 0 on entering RUN; frozen in other states.
REQ-018 round_done with outstanding=1 toggles bank and increments generation (mod 2^GW) in any state except IDLE; round_done with outstanding=0 ignored.
REQ-019 Pause/manual mid-round: outstanding round completes normally, bank still toggles.
REQ-020 Clear (any accepting state): next cycle state=IDLE, bank=0, generation=0, outstanding=0, counter=0, init_req pulses once.
REQ-021 Cursor moves one cell per cycle while in SET and dir one-hot; dir zero or multi-hot ignored.
REQ-022 WRAP=0: moves past edge ignored; WRAP=1: x=0 left -> COLS-1, x=COLS-1 right -> 0, same for y with ROWS.
REQ-023 cursor_addr updated incrementally (+/-1, +/-COLS, wrap adjustments) and always equals cursor_y*COLS+cursor_x.
REQ-024 All outputs registered.

Reset
REQ-025 rst: state=IDLE, bank=0, evo_start=0, edit_we=0, generation=0, outstanding=0, counter=0, cursor_x=COLS/2, cursor_y=ROWS/2, cursor_addr=(ROWS/2)*COLS+COLS/2; init_req pulses once the cycle after rst deasserts.
REQ-026 rst mid-round overrides everything; a later round_done is ignored.

Verification
REQ-027 BASE_TICKS=8, speed=1, load_done=1, start twice, round_done 3 cycles after each evo_start -> evo_start every 4 cycles, bank toggles each round, generation 1,2,3.
REQ-028 RUN, round_done withheld 20 cycles -> single evo_start, counter holds at P-1, next evo_start 1 cycle after round_done.
REQ-029 PAUSE, step -> state 4, one evo_start, round_done -> state 1, generation +1, no further evo_start.
REQ-030 WRAP=0, COLS=4, ROWS=3, SET, 5 left moves from x=2 -> x=0, addr=1*4+0=4; WRAP=1 one more left -> x=3, addr=7.
REQ-031 RUN with outstanding round, clear -> IDLE, bank=0, generation=0, init_req one pulse, subsequent round_done ignored.
REQ-032 IDLE, load_done=0, start -> stays IDLE; load_done=1, start -> PAUSE.

Source files
------------

// File: rtl/life_ctrl_if.sv
// Control/status bundle between the Life sequencer and its front panel,
// evolution engine and display path.
interface life_ctrl_if #(
  parameter int CW = 12,
  parameter int AW = 24,
  parameter int GW = 16
);
  // Front-panel and engine inputs to the controller
  logic          start;
  logic          pause;
  logic          clear;
  logic          step;
  logic          manual;
  logic [3:0]    dir;
  logic          edit;
  logic [2:0]    speed;
  logic          load_done;
  logic          round_done;

  // Controller outputs
  logic [2:0]    state;
  logic          bank;
  logic          evo_start;
  logic          init_req;
  logic          edit_we;
  logic [CW-1:0] cursor_x;
  logic [CW-1:0] cursor_y;
  logic [AW-1:0] cursor_addr;
  logic [GW-1:0] generation;

  // Environment side: drives requests, observes controller status
  modport master (
    output start, pause, clear, step, manual, dir, edit, speed,
           load_done, round_done,
    input  state, bank, evo_start, init_req, edit_we,
           cursor_x, cursor_y, cursor_addr, generation
  );

  // Controller side
  modport slave (
    input  start, pause, clear, step, manual, dir, edit, speed,
           load_done, round_done,
    output state, bank, evo_start, init_req, edit_we,
           cursor_x, cursor_y, cursor_addr, generation
  );
endinterface

// File: rtl/life_ctrl.sv
// Game-of-Life sequencer: run/pause/step/edit control, evolution pacing,
// ping-pong bank select, generation count and edit cursor.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | grid cleared or not yet loaded, waiting for start/manual
// PAUSE | grid loaded, evolution halted
// RUN   | free-running, one evolution round per tick period
// SET   | cursor/edit mode, returns to the state it was entered from
// STEP  | single evolution round, then back to PAUSE
module life_ctrl #(
  parameter int COLS       = 800,
  parameter int ROWS       = 600,
  parameter int CW         = 12,
  parameter int AW         = 24,
  parameter int GW         = 16,
  parameter int BASE_TICKS = 50000000,
  parameter int WRAP       = 0
) (
  input logic        clk,
  input logic        rst,
  life_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAUSE = 3'd1,
    S_RUN   = 3'd2,
    S_SET   = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  // Tick counter width: enough to hold BASE_TICKS-1 (the longest period)
  localparam int TW = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;

  localparam logic [TW-1:0] PM1_RST = TW'((BASE_TICKS > 1) ? BASE_TICKS - 1 : 0);
  localparam logic [CW-1:0] X_MAX   = CW'(COLS - 1);
  localparam logic [CW-1:0] Y_MAX   = CW'(ROWS - 1);
  localparam logic [CW-1:0] X_RST   = CW'(COLS / 2);
  localparam logic [CW-1:0] Y_RST   = CW'(ROWS / 2);
  localparam logic [AW-1:0] A_ROW   = AW'(COLS);
  localparam logic [AW-1:0] A_XSPAN = AW'(COLS - 1);
  localparam logic [AW-1:0] A_YSPAN = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] A_RST   = AW'((ROWS / 2) * COLS + COLS / 2);

  state_t        r_state, w_state_nxt;
  state_t        r_ret, w_ret_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_pm1, w_pm1_nxt;
  logic [TW-1:0] w_pm1_spd;
  logic [31:0]   w_period;
  logic          r_step_fired, w_step_fired_nxt;
  logic          r_outstanding;
  logic          r_bank;
  logic [GW-1:0] r_gen;
  logic          r_evo_start;
  logic          r_edit_we;
  logic          r_init_req;
  logic          r_init_pend;
  logic [CW-1:0] r_cursor_x, w_cursor_x_nxt;
  logic [CW-1:0] r_cursor_y, w_cursor_y_nxt;
  logic [AW-1:0] r_cursor_addr, w_cursor_addr_nxt;
  logic          w_fire;
  logic          w_clear;
  logic          w_edit;
  logic          w_done;
  logic          w_free;

  // A round finishes only if one was actually issued; a stray round_done
  // is ignored. The engine is free again in the same cycle its round ends,
  // so the next round can be issued back-to-back.
  assign w_done = bus.round_done & r_outstanding;
  assign w_free = ~r_outstanding | bus.round_done;

  // Period for the current speed, floored at one cycle, expressed as P-1
  always_comb begin
    w_period = 32'(BASE_TICKS) >> bus.speed;
    if (w_period == 32'd0) begin
      w_period = 32'd1;
    end
    w_pm1_spd = TW'(w_period - 32'd1);
  end

  // Next-state, pacing and pulse decisions
  always_comb begin
    w_state_nxt      = r_state;
    w_ret_nxt        = r_ret;
    w_cnt_nxt        = r_cnt;
    w_pm1_nxt        = r_pm1;
    w_step_fired_nxt = r_step_fired;
    w_fire           = 1'b0;
    w_clear          = 1'b0;
    w_edit           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && bus.load_done) begin
          w_state_nxt = S_PAUSE;
        end else if (bus.manual && bus.load_done) begin
          w_state_nxt = S_SET;
          w_ret_nxt   = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_pm1_nxt   = w_pm1_spd;
        end else if (bus.step) begin
          w_state_nxt      = S_STEP;
          w_step_fired_nxt = 1'b0;
        end else if (bus.clear) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else if (bus.manual) begin
          w_state_nxt = S_SET;
          w_ret_nxt   = S_PAUSE;
        end
      end
      S_RUN: begin
        if (bus.pause) begin
          w_state_nxt = S_PAUSE;
        end else if (bus.clear) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else if (r_cnt == r_pm1) begin
          // Terminal count holds until the engine is free
          if (w_free) begin
            w_fire    = 1'b1;
            w_cnt_nxt = '0;
            w_pm1_nxt = w_pm1_spd;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STEP: begin
        if (bus.clear) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else begin
          // A round left over from RUN must finish before ours is issued;
          // only the completion of our own round ends the step.
          if (!r_step_fired && w_free) begin
            w_fire           = 1'b1;
            w_step_fired_nxt = 1'b1;
          end
          if (r_step_fired && w_done) begin
            w_state_nxt = S_PAUSE;
          end
        end
      end
      S_SET: begin
        w_edit = bus.edit;
        if (!bus.manual) begin
          w_state_nxt = r_ret;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Cursor movement: one cell per cycle, only for a clean one-hot direction
  always_comb begin
    w_cursor_x_nxt    = r_cursor_x;
    w_cursor_y_nxt    = r_cursor_y;
    w_cursor_addr_nxt = r_cursor_addr;
    if (r_state == S_SET && $onehot(bus.dir)) begin
      if (bus.dir[0]) begin
        if (r_cursor_x != '0) begin
          w_cursor_x_nxt    = r_cursor_x - 1'b1;
          w_cursor_addr_nxt = r_cursor_addr - 1'b1;
        end else if (WRAP != 0) begin
          w_cursor_x_nxt    = X_MAX;
          w_cursor_addr_nxt = r_cursor_addr + A_XSPAN;
        end
      end else if (bus.dir[1]) begin
        if (r_cursor_y != '0) begin
          w_cursor_y_nxt    = r_cursor_y - 1'b1;
          w_cursor_addr_nxt = r_cursor_addr - A_ROW;
        end else if (WRAP != 0) begin
          w_cursor_y_nxt    = Y_MAX;
          w_cursor_addr_nxt = r_cursor_addr + A_YSPAN;
        end
      end else if (bus.dir[2]) begin
        if (r_cursor_y != Y_MAX) begin
          w_cursor_y_nxt    = r_cursor_y + 1'b1;
          w_cursor_addr_nxt = r_cursor_addr + A_ROW;
        end else if (WRAP != 0) begin
          w_cursor_y_nxt    = '0;
          w_cursor_addr_nxt = r_cursor_addr - A_YSPAN;
        end
      end else begin
        if (r_cursor_x != X_MAX) begin
          w_cursor_x_nxt    = r_cursor_x + 1'b1;
          w_cursor_addr_nxt = r_cursor_addr + 1'b1;
        end else if (WRAP != 0) begin
          w_cursor_x_nxt    = '0;
          w_cursor_addr_nxt = r_cursor_addr - A_XSPAN;
        end
      end
    end
  end

  // State register and return target for SET
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ret   <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  // Tick counter, sampled period and step bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_pm1        <= PM1_RST;
      r_step_fired <= 1'b0;
    end else begin
      r_cnt        <= w_clear ? '0 : w_cnt_nxt;
      r_pm1        <= w_pm1_nxt;
      r_step_fired <= w_step_fired_nxt;
    end
  end

  // Outstanding round, bank flip and generation count on round completion
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_outstanding <= 1'b0;
      r_bank        <= 1'b0;
      r_gen         <= '0;
    end else begin
      if (w_fire) begin
        r_outstanding <= 1'b1;
      end else if (w_done) begin
        r_outstanding <= 1'b0;
      end
      if (w_done && r_state != S_IDLE) begin
        r_bank <= ~r_bank;
        r_gen  <= r_gen + 1'b1;
      end
    end
  end

  // Single-cycle output pulses; init_req also fires right after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evo_start <= 1'b0;
      r_edit_we   <= 1'b0;
      r_init_req  <= 1'b0;
      r_init_pend <= 1'b1;
    end else begin
      r_evo_start <= w_fire;
      r_edit_we   <= w_edit;
      r_init_req  <= r_init_pend | w_clear;
      r_init_pend <= 1'b0;
    end
  end

  // Cursor position and its linear address, kept in step incrementally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cursor_x    <= X_RST;
      r_cursor_y    <= Y_RST;
      r_cursor_addr <= A_RST;
    end else begin
      r_cursor_x    <= w_cursor_x_nxt;
      r_cursor_y    <= w_cursor_y_nxt;
      r_cursor_addr <= w_cursor_addr_nxt;
    end
  end

  assign bus.state       = r_state;
  assign bus.bank        = r_bank;
  assign bus.evo_start   = r_evo_start;
  assign bus.init_req    = r_init_req;
  assign bus.edit_we     = r_edit_we;
  assign bus.cursor_x    = r_cursor_x;
  assign bus.cursor_y    = r_cursor_y;
  assign bus.cursor_addr = r_cursor_addr;
  assign bus.generation  = r_gen;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl on a 4x3 grid with an 8-cycle base period;
// a second instance with wrap enabled covers cursor wrap-around.
module tb_life_ctrl;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int CW   = 12;
  localparam int AW   = 24;
  localparam int GW   = 16;
  localparam int BT   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk    = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int rd_delay = 3;

  life_ctrl_if #(.CW(CW), .AW(AW), .GW(GW)) bus_a ();
  life_ctrl_if #(.CW(CW), .AW(AW), .GW(GW)) bus_b ();

  life_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .AW(AW), .GW(GW),
              .BASE_TICKS(BT), .WRAP(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  life_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .AW(AW), .GW(GW),
              .BASE_TICKS(BT), .WRAP(1)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge. Models an engine that
  // answers each evo_start with round_done rd_delay cycles later.
  task automatic cyc1();
    @(posedge clk);
    #1;
    bus_a.round_done = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) bus_a.round_done = 1'b1;
    end
    if (bus_a.evo_start) rd_cnt = rd_delay;
  endtask

  task automatic idle_inputs_b();
    bus_b.start = 0; bus_b.pause = 0; bus_b.clear = 0; bus_b.step = 0;
    bus_b.manual = 0; bus_b.dir = 4'b0000; bus_b.edit = 0; bus_b.speed = 3'd0;
    bus_b.load_done = 0; bus_b.round_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.start = 0; bus_a.pause = 0; bus_a.clear = 0; bus_a.step = 0;
    bus_a.manual = 0; bus_a.dir = 4'b0000; bus_a.edit = 0; bus_a.speed = 3'd0;
    bus_a.load_done = 0; bus_a.round_done = 0;
    idle_inputs_b();

    // Reset state
    repeat (3) cyc1();
    check_val("rst_state", bus_a.state, 0);
    check_val("rst_bank", bus_a.bank, 0);
    check_val("rst_gen", bus_a.generation, 0);
    check_val("rst_evo", bus_a.evo_start, 0);
    check_val("rst_x", bus_a.cursor_x, 2);
    check_val("rst_y", bus_a.cursor_y, 1);
    check_val("rst_addr", bus_a.cursor_addr, 6);
    rst = 1'b0;
    cyc1();
    check_val("init_req_after_rst", bus_a.init_req, 1);
    cyc1();
    check_val("init_req_one_pulse", bus_a.init_req, 0);

    // Start ignored until the grid is loaded
    bus_a.start = 1; cyc1(); bus_a.start = 0;
    check_val("start_no_load", bus_a.state, 0);
    bus_a.load_done = 1;
    bus_a.start = 1; cyc1(); bus_a.start = 0;
    check_val("start_loaded", bus_a.state, 1);

    // RUN at speed 1: period 4, engine answers in 3 cycles
    bus_a.speed = 3'd1;
    bus_a.start = 1; cyc1(); bus_a.start = 0;
    check_val("run_state", bus_a.state, 2);
    for (int k = 1; k <= 16; k++) begin
      cyc1();
      check_val($sformatf("run_evo_k%0d", k), bus_a.evo_start, (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 0) begin
        check_val($sformatf("run_gen_k%0d", k), bus_a.generation, k / 4 - 1);
        check_val($sformatf("run_bank_k%0d", k), bus_a.bank, (k / 4 - 1) % 2);
      end
    end

    // Pause mid-round: the round still completes and is counted
    bus_a.pause = 1; cyc1(); bus_a.pause = 0;
    check_val("pause_state", bus_a.state, 1);
    check_val("pause_evo", bus_a.evo_start, 0);
    cyc1(); cyc1();
    check_val("pause_gen_pending", bus_a.generation, 3);
    cyc1();
    check_val("pause_gen_done", bus_a.generation, 4);
    check_val("pause_bank_done", bus_a.bank, 0);

    // Single step
    bus_a.step = 1; cyc1(); bus_a.step = 0;
    check_val("step_state", bus_a.state, 4);
    check_val("step_evo_entry", bus_a.evo_start, 0);
    cyc1();
    check_val("step_evo", bus_a.evo_start, 1);
    for (int k = 0; k < 3; k++) begin
      cyc1();
      check_val($sformatf("step_wait_state%0d", k), bus_a.state, 4);
      check_val($sformatf("step_wait_evo%0d", k), bus_a.evo_start, 0);
    end
    cyc1();
    check_val("step_back_pause", bus_a.state, 1);
    check_val("step_gen", bus_a.generation, 5);
    check_val("step_bank", bus_a.bank, 1);
    for (int k = 0; k < 5; k++) begin
      cyc1();
      check_val($sformatf("step_no_evo%0d", k), bus_a.evo_start, 0);
    end

    // Stray round_done with nothing outstanding
    bus_a.round_done = 1; cyc1();
    check_val("stray_done_gen", bus_a.generation, 5);
    check_val("stray_done_bank", bus_a.bank, 1);

    // Slow engine: counter holds at terminal count
    rd_delay = 20;
    bus_a.start = 1; cyc1(); bus_a.start = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc1();
      check_val($sformatf("slow_evo_k%0d", k), bus_a.evo_start, (k == 4 || k == 25) ? 1 : 0);
    end
    check_val("slow_gen", bus_a.generation, 6);
    check_val("slow_bank", bus_a.bank, 0);

    // Clear with a round outstanding
    bus_a.clear = 1; cyc1(); bus_a.clear = 0;
    check_val("clear_state", bus_a.state, 0);
    check_val("clear_gen", bus_a.generation, 0);
    check_val("clear_bank", bus_a.bank, 0);
    check_val("clear_init_req", bus_a.init_req, 1);
    cyc1();
    check_val("clear_init_once", bus_a.init_req, 0);
    repeat (19) cyc1();
    check_val("late_done_gen", bus_a.generation, 0);
    check_val("late_done_bank", bus_a.bank, 0);
    check_val("late_done_state", bus_a.state, 0);

    // Cursor mode, clamping instance
    bus_a.manual = 1; cyc1();
    check_val("set_state", bus_a.state, 3);
    bus_a.dir = 4'b0001; repeat (5) cyc1(); bus_a.dir = 4'b0000;
    check_val("clamp_left_x", bus_a.cursor_x, 0);
    check_val("clamp_left_y", bus_a.cursor_y, 1);
    check_val("clamp_left_addr", bus_a.cursor_addr, 4);
    bus_a.edit = 1; cyc1(); bus_a.edit = 0;
    check_val("edit_we_pulse", bus_a.edit_we, 1);
    cyc1();
    check_val("edit_we_clear", bus_a.edit_we, 0);
    bus_a.start = 1; cyc1(); bus_a.start = 0;
    check_val("set_ignores_start", bus_a.state, 3);
    bus_a.dir = 4'b1001; cyc1();
    check_val("multihot_x", bus_a.cursor_x, 0);
    check_val("multihot_addr", bus_a.cursor_addr, 4);
    bus_a.dir = 4'b0100; repeat (3) cyc1();
    check_val("clamp_down_y", bus_a.cursor_y, 2);
    check_val("clamp_down_addr", bus_a.cursor_addr, 8);
    bus_a.dir = 4'b1000; repeat (5) cyc1();
    check_val("clamp_right_x", bus_a.cursor_x, 3);
    check_val("clamp_right_addr", bus_a.cursor_addr, 11);
    bus_a.dir = 4'b0010; cyc1();
    check_val("up_y", bus_a.cursor_y, 1);
    check_val("up_addr", bus_a.cursor_addr, 7);
    bus_a.dir = 4'b0000; bus_a.manual = 0; cyc1();
    check_val("set_return_idle", bus_a.state, 0);

    // Cursor mode, wrapping instance
    bus_b.load_done = 1; bus_b.manual = 1; cyc1();
    check_val("wrap_set_state", bus_b.state, 3);
    bus_b.dir = 4'b0001; cyc1(); cyc1();
    check_val("wrap_left_x0", bus_b.cursor_x, 0);
    check_val("wrap_left_addr0", bus_b.cursor_addr, 4);
    cyc1();
    check_val("wrap_left_x", bus_b.cursor_x, 3);
    check_val("wrap_left_addr", bus_b.cursor_addr, 7);
    bus_b.dir = 4'b0010; cyc1(); cyc1();
    check_val("wrap_up_y", bus_b.cursor_y, 2);
    check_val("wrap_up_addr", bus_b.cursor_addr, 11);
    bus_b.dir = 4'b1000; cyc1();
    check_val("wrap_right_x", bus_b.cursor_x, 0);
    check_val("wrap_right_addr", bus_b.cursor_addr, 8);
    bus_b.dir = 4'b0100; cyc1();
    check_val("wrap_down_y", bus_b.cursor_y, 0);
    check_val("wrap_down_addr", bus_b.cursor_addr, 0);
    bus_b.dir = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
